// File: rtl/mult8ux8s_arb.sv
// Two-requester arbiter sharing one pipelined 8u x 8s multiplier, with per-operation ownership tags.
// Define MULT_ARB_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module mult8ux8s_arb #(
  parameter int MULT_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic [7:0]  mul_n1,
  output logic [7:0]  mul_n2,
  input  logic [15:0] mul_result,
  output logic        resp0_valid,
  output logic [15:0] resp0_data,
  output logic        resp1_valid,
  output logic [15:0] resp1_data,
  output logic        idle
);

  localparam int DEPTH = MULT_LAT + 1;
  localparam int CW    = $clog2(MULT_LAT + 2);

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_hs;
  logic             w_retire;
  logic             w_retId;
  logic [DEPTH-1:0] r_tagVld;
  logic [DEPTH-1:0] r_tagId;
  logic [CW-1:0]    r_count;

`ifdef MULT_ARB_PRIO_EN
  always_comb begin
    w_gnt0 = req0_valid;
    w_gnt1 = req1_valid & ~req0_valid;
  end
`else
  // r_last remembers the most recent winner so a tie goes to the other side
  logic r_last;

  always_comb begin
    w_gnt0 = req0_valid & (~req1_valid | r_last);
    w_gnt1 = req1_valid & (~req0_valid | ~r_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_hs) begin
      r_last <= w_gnt1;
    end
  end
`endif

  assign req0_ready = w_gnt0 & rst_n;
  assign req1_ready = w_gnt1 & rst_n;
  assign w_hs       = req0_ready | req1_ready;
  assign w_retire   = r_tagVld[MULT_LAT];
  assign w_retId    = r_tagId[MULT_LAT];
  assign idle       = (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_n1 <= 8'h00;
      mul_n2 <= 8'h00;
    end else if (w_hs) begin
      mul_n1 <= w_gnt1 ? req1_a : req0_a;
      mul_n2 <= w_gnt1 ? req1_b : req0_b;
    end
  end

  // Stage MULT_LAT lines up with the multiplier output for the operands issued MULT_LAT edges earlier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tagVld <= '0;
      r_tagId  <= '0;
    end else begin
      r_tagVld <= {r_tagVld[DEPTH-2:0], w_hs};
      r_tagId  <= {r_tagId[DEPTH-2:0], w_gnt1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_data  <= 16'h0000;
      resp1_data  <= 16'h0000;
    end else begin
      resp0_valid <= w_retire & ~w_retId;
      resp1_valid <= w_retire & w_retId;
      if (w_retire && !w_retId) begin
        resp0_data <= mul_result;
      end
      if (w_retire && w_retId) begin
        resp1_data <= mul_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_hs && !w_retire) begin
      r_count <= r_count + CW'(1);
    end else if (!w_hs && w_retire) begin
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: tb/tb_mult8ux8s_arb.sv
// Directed bench for mult8ux8s_arb with a behavioural pipelined 8u x 8s multiplier model.
module tb_mult8ux8s_arb;

  localparam int LAT = 1;

  typedef struct {
    logic        port;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vecT;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } opT;

  typedef struct {
    logic        id;
    logic [15:0] data;
    int          due;
  } expT;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [7:0]  mul_n1, mul_n2;
  logic [15:0] mulResult;
  logic        resp0_valid, resp1_valid;
  logic [15:0] resp0_data, resp1_data;
  logic        idle;

  logic [15:0] mulPipe [LAT];
  int          cyc;
  int          totalCount;
  int          passCount;
  expT         sbQ [$];

  mult8ux8s_arb #(.MULT_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mul_n1(mul_n1), .mul_n2(mul_n2), .mul_result(mulResult),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data),
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mulRef(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] ea;
    logic signed [15:0] eb;
    ea = {8'h00, a};
    eb = {{8{b[7]}}, b};
    return ea * eb;
  endfunction

  always @(posedge clk) begin
    mulPipe[0] <= mulRef(mul_n1, mul_n2);
    for (int i = 1; i < LAT; i++) mulPipe[i] <= mulPipe[i-1];
    cyc <= cyc + 1;
  end
  assign mulResult = mulPipe[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic applyStimulus(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                               input logic v1, input logic [7:0] a1, input logic [7:0] b1);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    #1;
  endtask

  task automatic pushExp(input logic id, input logic [15:0] data);
    expT e;
    e.id = id; e.data = data; e.due = cyc + LAT + 2;
    sbQ.push_back(e);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 20 && sbQ.size() > 0; i++) @(negedge clk);
    checkOutput("drainTimeout", sbQ.size(), 0);
  endtask

  // Every strobe must match the oldest outstanding issue in owner, data and arrival cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp0_valid || resp1_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedStrobe", {resp1_valid, resp0_valid}, 0);
        end else begin
          expT e;
          e = sbQ.pop_front();
          checkOutput("resp0Valid", resp0_valid, !e.id);
          checkOutput("resp1Valid", resp1_valid, e.id);
          checkOutput("respData", e.id ? resp1_data : resp0_data, e.data);
          checkOutput("respCycle", cyc, e.due);
        end
      end else if (sbQ.size() > 0 && sbQ[0].due < cyc) begin
        checkOutput("missedStrobeCycle", cyc, sbQ[0].due);
        void'(sbQ.pop_front());
      end
    end
  end

  vecT vecs [7];
  opT  ops0 [3];
  opT  ops1 [3];
  int  expGrant [6];

  initial begin
    int i0, i1, strobes;
    logic g;

    vecs[0] = '{1'b0, 8'h55, 8'h55, 16'h1C39};
    vecs[1] = '{1'b0, 8'h00, 8'hFF, 16'h0000};
    vecs[2] = '{1'b0, 8'hFF, 8'h00, 16'h0000};
    vecs[3] = '{1'b1, 8'h55, 8'hFF, 16'hFFAB};
    vecs[4] = '{1'b1, 8'hFF, 8'h80, 16'h8080};
    vecs[5] = '{1'b0, 8'hFF, 8'h7F, 16'h7E81};
    vecs[6] = '{1'b1, 8'hAA, 8'h81, 16'hABAA};
    ops0[0] = '{8'hFF, 8'h81, 16'h817F};
    ops0[1] = '{8'hFF, 8'h7F, 16'h7E81};
    ops0[2] = '{8'hAA, 8'h81, 16'hABAA};
    ops1[0] = '{8'hAA, 8'h81, 16'hABAA};
    ops1[1] = '{8'hFF, 8'h81, 16'h817F};
    ops1[2] = '{8'hFF, 8'h7F, 16'h7E81};
`ifdef MULT_ARB_PRIO_EN
    expGrant = '{0, 0, 0, 1, 1, 1};
`else
    expGrant = '{0, 1, 0, 1, 0, 1};
`endif

    totalCount = 0;
    passCount  = 0;
    cyc        = 0;
    rst_n      = 1'b0;
    applyStimulus(0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);

    applyStimulus(1, 8'h12, 8'h34, 1, 8'h56, 8'h78);
    checkOutput("rstReady0", req0_ready, 0);
    checkOutput("rstReady1", req1_ready, 0);
    checkOutput("rstMulN1", mul_n1, 0);
    checkOutput("rstMulN2", mul_n2, 0);
    checkOutput("rstRespValid", {resp1_valid, resp0_valid}, 0);
    checkOutput("rstResp0Data", resp0_data, 0);
    checkOutput("rstResp1Data", resp1_data, 0);
    checkOutput("rstIdle", idle, 1);
    applyStimulus(0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests straight after reset: req0 first, then req1
    @(negedge clk);
    applyStimulus(1, 8'hFF, 8'h80, 1, 8'h55, 8'hFF);
    checkOutput("tieFirstReady0", req0_ready, 1);
    checkOutput("tieFirstReady1", req1_ready, 0);
    pushExp(1'b0, 16'h8080);
    @(negedge clk);
    applyStimulus(0, 8'hFF, 8'h80, 1, 8'h55, 8'hFF);
    checkOutput("tieSecondReady0", req0_ready, 0);
    checkOutput("tieSecondReady1", req1_ready, 1);
    pushExp(1'b1, 16'hFFAB);
    @(negedge clk);
    applyStimulus(0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("tieBusy", idle, 0);
    waitDrain();
    @(negedge clk);
    checkOutput("tieIdleAfter", idle, 1);

    for (int k = 0; k < 7; k++) begin
      checkOutput("vecIdleBefore", idle, 1);
      if (vecs[k].port) applyStimulus(0, 8'h00, 8'h00, 1, vecs[k].a, vecs[k].b);
      else              applyStimulus(1, vecs[k].a, vecs[k].b, 0, 8'h00, 8'h00);
      checkOutput("vecReady0", req0_ready, !vecs[k].port);
      checkOutput("vecReady1", req1_ready, vecs[k].port);
      pushExp(vecs[k].port, vecs[k].prod);
      @(negedge clk);
      applyStimulus(0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
      checkOutput("vecIdleFalls", idle, 0);
      checkOutput("vecMulN1", mul_n1, vecs[k].a);
      checkOutput("vecMulN2", mul_n2, vecs[k].b);
      waitDrain();
      @(negedge clk);
      checkOutput("vecIdleRises", idle, 1);
      checkOutput("vecDataHeld", vecs[k].port ? resp1_data : resp0_data, vecs[k].prod);
    end

    // Continuous dual demand from a fresh reset so the pointer starts favouring req0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(i0 < 3, ops0[i0 % 3].a, ops0[i0 % 3].b, i1 < 3, ops1[i1 % 3].a, ops1[i1 % 3].b);
      g = (expGrant[k] == 1);
      checkOutput("dualReady0", req0_ready, !g);
      checkOutput("dualReady1", req1_ready, g);
      if (g) begin
        pushExp(1'b1, ops1[i1].prod);
        i1++;
      end else begin
        pushExp(1'b0, ops0[i0].prod);
        i0++;
      end
      @(negedge clk);
    end
    applyStimulus(0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    waitDrain();
    @(negedge clk);
    checkOutput("dualIdle", idle, 1);

    // Reset one cycle after a handshake drops the in-flight operation
    applyStimulus(1, 8'h55, 8'h55, 0, 8'h00, 8'h00);
    checkOutput("midReady0", req0_ready, 1);
    @(negedge clk);
    applyStimulus(0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sbQ.delete();
    checkOutput("midIdle", idle, 1);
    checkOutput("midMulN1", mul_n1, 0);
    checkOutput("midMulN2", mul_n2, 0);
    strobes = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) rst_n = 1'b1;
      if (resp0_valid || resp1_valid) strobes++;
    end
    checkOutput("midNoStrobe", strobes, 0);
    checkOutput("midIdleAfter", idle, 1);

    waitDrain();
    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
